// File: rtl/pong_frame_scheduler.sv
// Frame scheduler for the pong game: frame tick plus a vertical-blanking update window
// in which the two position-register writers are granted access round-robin.
module pong_frame_scheduler #(
  parameter int VD        = 480,
  parameter int VMAX      = 524,
  parameter int WIN_START = 481,
  parameter int WIN_END   = 520,
  parameter int FCW       = 8
) (
  input  logic           clk_100MHz,
  input  logic           reset,
  input  logic           p_tick,
  input  logic           video_on,
  input  logic [9:0]     x,
  input  logic [9:0]     y,
  input  logic [1:0]     req,
  input  logic           overrun_clr,
  output logic [1:0]     gnt,
  output logic           upd_window,
  output logic           frame_tick,
  output logic [FCW-1:0] frame_count,
  output logic           overrun,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, WINDOW, GRANT} state_t;

  state_t     state;
  logic       rr_ptr;
  logic       line_start;
  logic       ev_frame;
  logic       ev_open;
  logic       ev_close;
  logic [1:0] pick;

  assign line_start = p_tick && (x == 10'd0);
  assign ev_frame   = line_start && (y == 10'(VD));
  assign ev_open    = line_start && (y == 10'(WIN_START));
  assign ev_close   = line_start && (y == 10'(WIN_END));
  assign busy       = |gnt;

  // rr_ptr names the requester that wins the next contended grant
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = rr_ptr ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_tick <= ev_frame;
      if (ev_frame) frame_count <= frame_count + 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      upd_window <= 1'b0;
      rr_ptr     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // a set issued further down in the same cycle overrides this clear
      if (overrun_clr) overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_open) begin
            state      <= WINDOW;
            upd_window <= 1'b1;
          end
        end
        WINDOW: begin
          if (ev_close) begin
            state      <= IDLE;
            upd_window <= 1'b0;
          end else if (req != 2'b00) begin
            state <= GRANT;
            gnt   <= pick;
            if (req == 2'b11) rr_ptr <= ~rr_ptr;
          end
        end
        GRANT: begin
          if (ev_close) begin
            state      <= IDLE;
            upd_window <= 1'b0;
            gnt        <= 2'b00;
            if ((req & gnt) != 2'b00) overrun <= 1'b1;
          end else if ((req & gnt) == 2'b00) begin
            // always pass through WINDOW so grants are separated by a dead cycle
            state <= WINDOW;
            gnt   <= 2'b00;
          end
        end
        default: begin
          state      <= IDLE;
          gnt        <= 2'b00;
          upd_window <= 1'b0;
        end
      endcase
    end
  end

  a_no_update_while_drawing: assert property (@(posedge clk_100MHz) disable iff (reset)
    !(upd_window && video_on));
  a_y_in_range: assert property (@(posedge clk_100MHz) disable iff (reset)
    y <= 10'(VMAX));

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// Bench for pong_frame_scheduler: drives a compressed scan (selected lines, few pixels per
// line) and checks every cycle against a behavioural model of the window/grant rules.
module tb_pong_frame_scheduler;

  localparam int NPIX      = 4;
  localparam int PER       = 4;
  localparam int NLN       = 15;
  localparam int LCYC      = NPIX * PER;
  localparam int FRAME_CYC = NLN * LCYC;

  int LN [NLN]  = '{0, 1, 479, 480, 481, 482, 485, 490, 500, 515, 519, 520, 521, 523, 524};
  int XV [NPIX] = '{0, 1, 639, 799};

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       p_tick;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] req;
  logic       overrun_clr;
  logic [1:0] gnt;
  logic       upd_window;
  logic       frame_tick;
  logic [7:0] frame_count;
  logic       overrun;
  logic       busy;
  logic [13:0] dut_vec;

  int tests = 0;
  int fails = 0;
  int kk    = 0;

  // reference model state
  bit m_open;
  int m_hold;
  int m_fav;
  bit m_ftick;
  int m_fcnt;
  bit m_ovr;

  pong_frame_scheduler #(.VD(480), .VMAX(524), .WIN_START(481), .WIN_END(520), .FCW(8)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .req        (req),
    .overrun_clr(overrun_clr),
    .gnt        (gnt),
    .upd_window (upd_window),
    .frame_tick (frame_tick),
    .frame_count(frame_count),
    .overrun    (overrun),
    .busy       (busy)
  );

  assign dut_vec = {gnt, upd_window, frame_tick, frame_count, overrun, busy};

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic model_reset();
    m_open = 0; m_hold = -1; m_fav = 0; m_ftick = 0; m_fcnt = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit ls, evf, evo, evc, set_ovr;
    ls  = p_tick && (x == 0);
    evf = ls && (y == 480);
    evo = ls && (y == 481);
    evc = ls && (y == 520);
    m_ftick = evf;
    if (evf) m_fcnt = (m_fcnt + 1) % 256;
    set_ovr = 0;
    if (!m_open) m_open = evo;
    else if (evc) begin
      set_ovr = (m_hold >= 0) && req[m_hold];
      m_open = 0;
      m_hold = -1;
    end else if (m_hold >= 0) begin
      if (!req[m_hold]) m_hold = -1;
    end else if (req == 2'b11) begin
      m_hold = m_fav;
      m_fav  = 1 - m_fav;
    end else if (req != 2'b00) m_hold = req[1] ? 1 : 0;
    if (set_ovr) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
  endtask

  function automatic logic [13:0] exp_vec();
    logic [1:0] g;
    g = (m_hold < 0) ? 2'b00 : ((m_hold == 0) ? 2'b01 : 2'b10);
    return {g, m_open, m_ftick, 8'(m_fcnt), m_ovr, (m_hold >= 0)};
  endfunction

  function automatic int line_of(input int k);
    return LN[(k % FRAME_CYC) / LCYC];
  endfunction

  task automatic cyc(input bit pt);
    p_tick   = pt;
    video_on = (x < 10'd640) && (y < 10'd480);
    @(posedge clk_100MHz);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic step_scan(input int k);
    int f;
    f = k % FRAME_CYC;
    x = 10'(XV[(f / PER) % NPIX]);
    y = 10'(LN[f / LCYC]);
    cyc((f % PER) == 0);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1; req = 2'b00; overrun_clr = 1'b0; p_tick = 1'b0; x = '0; y = '0; video_on = 1'b1;
    #2;
    tests++;
    if (dut_vec !== 14'd0) begin fails++; $display("FAIL reset_async got=%h exp=%h", dut_vec, 14'd0); end
    cyc(1'b0);
    cyc(1'b0);
    tests++;
    if (dut_vec !== 14'd0) begin fails++; $display("FAIL reset_hold got=%h exp=%h", dut_vec, 14'd0); end
    reset = 1'b0;
    kk = 0;
  endtask

  task automatic test_full_frame();
    int ticks, win, exp_win;
    ticks = 0; win = 0; exp_win = 0;
    for (int i = 0; i < NLN; i++) if (LN[i] >= 481 && LN[i] < 520) exp_win += LCYC;
    req = 2'b00;
    repeat (FRAME_CYC) begin
      step_scan(kk);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL full_frame k=%0d y=%0d got=%h exp=%h", kk, y, dut_vec, exp_vec()); end
      ticks += int'(frame_tick);
      win   += int'(upd_window);
      kk++;
    end
    tests++;
    if (ticks !== 1) begin fails++; $display("FAIL frame_tick_pulses got=%0d exp=1", ticks); end
    tests++;
    if (win !== exp_win) begin fails++; $display("FAIL window_cycles got=%0d exp=%0d", win, exp_win); end
    tests++;
    if (frame_count !== 8'd1) begin fails++; $display("FAIL frame_count_one got=%0d exp=1", frame_count); end
  endtask

  task automatic test_single();
    int rise_k, fall_k, ln, lc;
    rise_k = -1; fall_k = -1; req = 2'b00;
    repeat (FRAME_CYC) begin
      ln = line_of(kk); lc = kk % LCYC;
      if (ln == 485 && lc == 0) begin req = 2'b01; rise_k = kk; end
      if (rise_k >= 0 && kk == rise_k + 40) begin req = 2'b00; fall_k = kk; end
      step_scan(kk);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL single k=%0d y=%0d got=%h exp=%h", kk, y, dut_vec, exp_vec()); end
      if (kk == rise_k) begin
        tests++;
        if (gnt !== 2'b01) begin fails++; $display("FAIL single_grant got=%b exp=01", gnt); end
      end
      if (kk == fall_k) begin
        tests++;
        if (gnt !== 2'b00) begin fails++; $display("FAIL single_release got=%b exp=00", gnt); end
      end
      kk++;
    end
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL single_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_contention();
    int k0, ln, lc;
    logic [1:0] last;
    logic [1:0] seq[$];
    logic [1:0] want [4];
    want = '{2'b01, 2'b00, 2'b10, 2'b00};
    for (int fi = 0; fi < 2; fi++) begin
      k0 = -1; last = 2'b00;
      repeat (FRAME_CYC) begin
        ln = line_of(kk); lc = kk % LCYC;
        if (ln == 482 && lc == 0) begin req = 2'b11; k0 = kk; end
        if (fi == 0 && k0 >= 0 && kk == k0 + 20) req = 2'b10;
        if (fi == 0 && k0 >= 0 && kk == k0 + 40) req = 2'b00;
        if (fi == 1 && k0 >= 0 && kk == k0 + 10) req = 2'b00;
        step_scan(kk);
        tests++;
        if (dut_vec !== exp_vec()) begin fails++; $display("FAIL contention k=%0d y=%0d got=%h exp=%h", kk, y, dut_vec, exp_vec()); end
        if (fi == 0 && gnt !== last) begin seq.push_back(gnt); last = gnt; end
        if (fi == 0 && k0 >= 0 && kk == k0 + 20) begin
          tests++;
          if (gnt !== 2'b00) begin fails++; $display("FAIL dead_cycle got=%b exp=00", gnt); end
        end
        if (fi == 0 && k0 >= 0 && kk == k0 + 21) begin
          tests++;
          if (gnt !== 2'b10) begin fails++; $display("FAIL second_grant got=%b exp=10", gnt); end
        end
        if (fi == 1 && kk == k0) begin
          tests++;
          if (gnt !== 2'b10) begin fails++; $display("FAIL round_robin got=%b exp=10", gnt); end
        end
        kk++;
      end
    end
    tests++;
    if (seq.size() !== 4) begin fails++; $display("FAIL gnt_seq_len got=%0d exp=4", seq.size()); end
    else for (int i = 0; i < 4; i++) begin
      tests++;
      if (seq[i] !== want[i]) begin fails++; $display("FAIL gnt_seq[%0d] got=%b exp=%b", i, seq[i], want[i]); end
    end
  endtask

  task automatic test_overrun();
    int ln, lc, fi;
    for (int n = 0; n < 2 * FRAME_CYC; n++) begin
      fi = n / FRAME_CYC; ln = line_of(kk); lc = kk % LCYC;
      if (fi == 0 && ln == 515 && lc == 0) req = 2'b10;
      overrun_clr = (fi == 0 && ln == 520 && lc == 0) || (fi == 1 && ln == 1 && lc == 0);
      if (fi == 1 && ln == 0 && lc == 0) req = 2'b00;
      step_scan(kk);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL overrun_frame k=%0d y=%0d got=%h exp=%h", kk, y, dut_vec, exp_vec()); end
      if (fi == 0 && ln == 520 && lc == 0) begin
        tests++;
        if ({gnt, upd_window, overrun} !== 4'b0001) begin
          fails++; $display("FAIL overrun_close got=%b exp=0001", {gnt, upd_window, overrun});
        end
      end
      if (fi == 0 && ln == 523 && lc == 0) begin
        tests++;
        if (gnt !== 2'b00) begin fails++; $display("FAIL idle_request got=%b exp=00", gnt); end
      end
      if (fi == 1 && ln == 1 && lc == 0) begin
        tests++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
      end
      kk++;
    end
    overrun_clr = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    int ln, lc, fi, leak;
    bit armed, resumed;
    leak = 0; armed = 0; resumed = 0;
    for (int n = 0; n < 2 * FRAME_CYC; n++) begin
      fi = n / FRAME_CYC; ln = line_of(kk); lc = kk % LCYC;
      if (fi == 0 && ln == 485 && lc == 0) req = 2'b01;
      if (fi == 0 && ln == 490 && lc == 5) begin
        tests++;
        if (gnt !== 2'b01) begin fails++; $display("FAIL pre_reset_grant got=%b exp=01", gnt); end
        reset = 1'b1;
        #1;
        model_reset();
        tests++;
        if (dut_vec !== 14'd0) begin fails++; $display("FAIL reset_mid_grant got=%h exp=%h", dut_vec, 14'd0); end
        armed = 1;
      end
      if (fi == 0 && ln == 490 && lc == 7) reset = 1'b0;
      if (fi == 1 && ln == 490 && lc == 0) req = 2'b00;
      step_scan(kk);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL reset_mid k=%0d y=%0d got=%h exp=%h", kk, y, dut_vec, exp_vec()); end
      if (fi == 1 && ln == 481 && lc == 1) begin
        resumed = 1;
        tests++;
        if (gnt !== 2'b01) begin fails++; $display("FAIL grant_after_reset got=%b exp=01", gnt); end
      end
      if (armed && !resumed && gnt !== 2'b00) leak++;
      kk++;
    end
    tests++;
    if (leak !== 0) begin fails++; $display("FAIL grant_leak got=%0d exp=0", leak); end
  endtask

  task automatic test_random();
    repeat (3 * FRAME_CYC) begin
      for (int i = 0; i < 2; i++) if ($urandom_range(15) == 0) req[i] = ~req[i];
      overrun_clr = ($urandom_range(31) == 0);
      step_scan(kk);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random k=%0d y=%0d req=%b got=%h exp=%h", kk, y, req, dut_vec, exp_vec()); end
      kk++;
    end
    req = 2'b00;
    overrun_clr = 1'b0;
  endtask

  task automatic test_wrap();
    int ticks;
    bit saw_wrap;
    logic [7:0] start;
    ticks = 0; saw_wrap = 0; start = frame_count;
    repeat (256 * FRAME_CYC) begin
      step_scan(kk);
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL wrap k=%0d y=%0d got=%h exp=%h", kk, y, dut_vec, exp_vec()); end
      if (frame_tick) begin
        ticks++;
        if (frame_count == 8'd0) saw_wrap = 1;
      end
      kk++;
    end
    tests++;
    if (ticks !== 256) begin fails++; $display("FAIL wrap_ticks got=%0d exp=256", ticks); end
    tests++;
    if (frame_count !== start) begin fails++; $display("FAIL wrap_count got=%0d exp=%0d", frame_count, start); end
    tests++;
    if (!saw_wrap) begin fails++; $display("FAIL wrap_to_zero got=0 exp=1"); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_single();
    test_contention();
    test_overrun();
    test_reset_mid_grant();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
